div: RTL and testbench
======================

Name: div

Overview:
- Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU; it is the producer side of the pipeline stall protocol.
- Instantiated beside the execute stage. ex pulses start_i with operands and holds stallreq high while ready_o is low, so upstream pipeline registers freeze.
- Produces {remainder, quotient} for the HI/LO write-back path.

Parameters:
- None. Datapath width is fixed at 32 bits (`RegBus`).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high (`RstEnable` = 1)
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- start_i  in  1  `DivStart` requests an operation; held high until ready_o is seen, then dropped
- annul_i  in  1  cancel the in-flight division (flush, or branch-delay kill)
- result_o  out  64  {remainder[63:32], quotient[31:0]}
- ready_o  out  1  `DivResultReady` when result_o is valid

Behaviour:
- Reset (async, rst=1): state=DivFree, cnt=0, dividend reg=0, result_o=0, ready_o=`DivResultNotReady`. Reset mid-operation aborts immediately, with no partial result.
- State register is 2 bits: DivFree, DivByZero, DivOn, DivEnd. There are 6-bit cnt, 65-bit dividend, 32-bit divisor regs.
- DivFree:
  - start_i=1 && annul_i=0 && opdata2_i==0 -> DivByZero.
  - start_i=1 && annul_i=0 && opdata2_i!=0 -> DivOn, cnt<=0, dividend<={32'b0, |op1|, 1'b0}, divisor<=|op2|. Magnitudes are taken only when signed_div_i=1 and the operand MSB=1; otherwise the raw value is used. Operands and sign flags are latched at this edge; later input changes are ignored.
  - Otherwise stay; ready_o=0, result_o=0.
- DivByZero: next edge -> DivEnd with dividend cleared, so result_o=0.
- DivOn:
  - annul_i=1 -> DivFree next edge, regs cleared, ready_o stays 0.
  - cnt!=32, one iteration per edge:
    - tmp = {1'b0, dividend[63:32]} - {1'b0, divisor}.
    - If tmp[32]=1: dividend <= {dividend[63:0], 1'b0}.
    - Else: dividend <= {tmp[31:0], dividend[31:0], 1'b1}.
    - cnt++.
  - cnt==32 -> DivEnd, cnt<=0, and in the same edge:
    - result_o <= {rem, quo} with rem = dividend[64:33], quo = dividend[31:0];
    - ready_o <= 1.
    - Signed fixup: quo is negated (two's complement) if op1 sign != op2 sign; rem is negated if op1 sign = 1.
- DivEnd: ready_o=1 and result_o held while start_i=1. start_i=0 -> DivFree, ready_o<=0, result_o<=0. annul_i is ignored in DivEnd.
- Latency, counted from the edge E0 that samples start_i in DivFree:
  - nonzero divisor: ready_o high after E33;
  - zero divisor: ready_o high after E2.
- Arithmetic:
  - All magnitudes are unsigned 32-bit. |0x80000000| = 0x80000000, no trap.
  - Overflow case 0x80000000/-1 wraps: quo=0x80000000, rem=0.
  - No HI/LO write of its own; the consumer decides.
- Simultaneous start_i and annul_i in DivFree: annul wins, no start.

Decomposition:
- defines.v gets:
  - DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11;
  - DivResultReady 1'b1, DivResultNotReady 1'b0;
  - DivStart 1'b1, DivStop 1'b0;
  - EXE_DIV_OP, EXE_DIVU_OP aluop codes.
- No sub-module: the subtract/shift step is a single expression in the DivOn branch. The ex stage owns stallreq generation and the stall[5:0] fan-out remains in ctrl.

Test Plan:
- Unsigned 7/2 (signed_div_i=0): start at E0 -> ready_o rises after E33, result_o=0x00000001_00000003; drop start -> next edge ready_o=0, result_o=0.
- Signed -7/2 (op1=0xFFFFFFF9, op2=2) -> result_o=0xFFFFFFFF_FFFFFFFD. Signed 7/-2 -> 0x00000001_FFFFFFFD.
- Divide by zero (op2=0, either sign mode) -> ready_o high after E2, result_o=0. Hold start 5 cycles -> result held and ready_o stays 1.
- Annul: start 100/3, assert annul_i at E10 -> state DivFree, ready_o never asserts. A fresh start of 100/3 then returns 0x00000001_00000021 at E33.
- Corners:
  - signed 0x80000000/0xFFFFFFFF -> 0x00000000_80000000;
  - unsigned 0xFFFFFFFF/1 -> 0x00000000_FFFFFFFF;
  - changing opdata1_i during DivOn does not affect the result.
- Async reset asserted at mid-iteration (E15, between clock edges) -> outputs zero immediately without a clock edge. A subsequent start works normally.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants for the multi-cycle DIV/DIVU unit: FSM encodings, handshake
// levels and the aluop codes that select it.
package div_pkg;

  localparam int unsigned RegBus = 32;

  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  // Two's-complement negate when en is set, pass-through otherwise.
  function automatic logic [RegBus-1:0] cond_neg(input logic [RegBus-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider for MIPS DIV/DIVU; one quotient bit per cycle,
// result held with ready_o high until the requester drops start_i.
module div
  import div_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              signed_div_i,
  input  logic [RegBus-1:0] opdata1_i,
  input  logic [RegBus-1:0] opdata2_i,
  input  logic              start_i,
  input  logic              annul_i,
  output logic [63:0]       result_o,
  output logic              ready_o
);

  logic [1:0]        state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [64:0]       dividend_q, dividend_d;
  logic [RegBus-1:0] divisor_q, divisor_d;
  logic              neg1_q, neg1_d;
  logic              neg2_q, neg2_d;
  logic [63:0]       result_q, result_d;
  logic              ready_q, ready_d;

  logic [RegBus:0]   tmp;
  logic              op1_neg, op2_neg;
  logic [RegBus-1:0] quo_fix, rem_fix;

  assign op1_neg = signed_div_i & opdata1_i[RegBus-1];
  assign op2_neg = signed_div_i & opdata2_i[RegBus-1];
  assign tmp     = {1'b0, dividend_q[63:32]} - {1'b0, divisor_q};
  assign quo_fix = cond_neg(dividend_q[31:0], neg1_q ^ neg2_q);
  assign rem_fix = cond_neg(dividend_q[64:33], neg1_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    neg1_d     = neg1_q;
    neg2_d     = neg2_q;
    result_d   = result_q;
    ready_d    = ready_q;
    unique case (state_q)
      DivFree: begin
        ready_d  = DivResultNotReady;
        result_d = '0;
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            state_d    = DivOn;
            cnt_d      = '0;
            dividend_d = {32'b0, cond_neg(opdata1_i, op1_neg), 1'b0};
            divisor_d  = cond_neg(opdata2_i, op2_neg);
            neg1_d     = op1_neg;
            neg2_d     = op2_neg;
          end
        end
      end
      DivByZero: begin
        state_d    = DivEnd;
        dividend_d = '0;
      end
      DivOn: begin
        if (annul_i) begin
          state_d    = DivFree;
          cnt_d      = '0;
          dividend_d = '0;
          divisor_d  = '0;
          ready_d    = DivResultNotReady;
          result_d   = '0;
        end else if (cnt_q != 6'd32) begin
          // Borrow out means the trial subtraction failed: shift in a 0 bit.
          if (tmp[RegBus]) begin
            dividend_d = {dividend_q[63:0], 1'b0};
          end else begin
            dividend_d = {tmp[31:0], dividend_q[31:0], 1'b1};
          end
          cnt_d = cnt_q + 6'd1;
        end else begin
          state_d  = DivEnd;
          cnt_d    = '0;
          result_d = {rem_fix, quo_fix};
          ready_d  = DivResultReady;
        end
      end
      DivEnd: begin
        if (start_i == DivStop) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
        end else begin
          ready_d = DivResultReady;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DivFree;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      neg1_q     <= 1'b0;
      neg2_q     <= 1'b0;
      result_q   <= '0;
      ready_q    <= DivResultNotReady;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      neg1_q     <= neg1_d;
      neg2_q     <= neg2_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: vector table through a result scoreboard, plus
// annul, simultaneous start/annul and asynchronous reset sequences.
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
    int          hold;
  } vec_t;

  vec_t        vecs[11];
  logic [63:0] sb_q[$];
  int          checks;
  int          errors;
  logic [31:0] cur_a, cur_b;
  logic        cur_sgn;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
    @(posedge clk); #1;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    cur_sgn      = sgn;
    cur_a        = a;
    cur_b        = b;
    sb_q.push_back(exp);
  endtask

  // Returns edge index (E0 = 0) after which ready_o is first seen, -1 on timeout.
  // Operands are scrambled right after E0 to prove they were latched.
  task automatic wait_ready(output int lat);
    lat = -1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        opdata1_i    = ~cur_a;
        opdata2_i    = cur_b ^ 32'h5;
        signed_div_i = ~cur_sgn;
      end
      if (ready_o) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic finish_op(input string name, input int lat, input int exp_lat, input int hold);
    logic [63:0] exp;
    exp = sb_q.pop_front();
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    if (lat >= 0) begin
      check({name, " result"}, result_o, exp);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        check({name, " hold ready"}, 64'(ready_o), 64'd1);
        check({name, " hold result"}, result_o, exp);
      end
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    check({name, " release ready"}, 64'(ready_o), 64'd0);
    check({name, " release result"}, result_o, 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    start_op(v.sgn, v.a, v.b, v.exp);
    wait_ready(lat);
    finish_op(v.name, lat, v.lat, v.hold);
  endtask

  // Watches ready_o for n cycles; reports whether it ever rose.
  task automatic watch_idle(input string name, input int n);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (ready_o) seen = 1'b1;
    end
    check(name, 64'(seen), 64'd0);
  endtask

  initial begin
    int   lat;
    vec_t annul_vec;
    checks = 0;
    errors = 0;

    vecs[0]  = '{"u 7/2",        1'b0, 32'd7,        32'd2,        64'h00000001_00000003, 33, 0};
    vecs[1]  = '{"s -7/2",       1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 33, 0};
    vecs[2]  = '{"s 7/-2",       1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 0};
    vecs[3]  = '{"s min/-1",     1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 1};
    vecs[4]  = '{"u max/1",      1'b0, 32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF, 33, 0};
    vecs[5]  = '{"u 5/0",        1'b0, 32'd5,        32'd0,        64'h0,                 2,  5};
    vecs[6]  = '{"s -7/0",       1'b1, 32'hFFFFFFF9, 32'd0,        64'h0,                 2,  5};
    vecs[7]  = '{"u 100/3",      1'b0, 32'd100,      32'd3,        64'h00000001_00000021, 33, 0};
    vecs[8]  = '{"u 8000/ffff",  1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 33, 0};
    vecs[9]  = '{"s -100/-7",    1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 33, 2};
    vecs[10] = '{"u 0/9",        1'b0, 32'd0,        32'd9,        64'h0,                 33, 0};

    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    #12;
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset result", result_o, 64'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Annul in flight at E10: no result may ever appear.
    start_op(1'b0, 32'd100, 32'd3, 64'h0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
    end
    annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0;
    start_i = 1'b0;
    void'(sb_q.pop_front());
    watch_idle("annul no ready", 40);
    annul_vec = '{"after annul 100/3", 1'b0, 32'd100, 32'd3, 64'h00000001_00000021, 33, 0};
    run_vec(annul_vec);

    // start and annul together in DivFree: annul wins.
    @(posedge clk); #1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd9;
    opdata2_i    = 32'd0;
    start_i      = 1'b1;
    annul_i      = 1'b1;
    for (int k = 0; k < 3; k++) @(posedge clk);
    #1;
    start_i = 1'b0;
    annul_i = 1'b0;
    watch_idle("start+annul no ready", 10);

    // Async reset mid-iteration, between edges, after E15.
    start_op(1'b0, 32'd7, 32'd2, 64'h0);
    for (int k = 0; k <= 15; k++) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midop reset ready", 64'(ready_o), 64'd0);
    check("midop reset result", result_o, 64'd0);
    start_i = 1'b0;
    void'(sb_q.pop_front());
    #2;
    rst = 1'b0;
    watch_idle("midop reset aborted", 40);

    // Async reset while a result is held clears it without a clock edge.
    start_op(1'b0, 32'd7, 32'd2, 64'h00000001_00000003);
    wait_ready(lat);
    check("pre-reset latency", 64'(lat), 64'd33);
    check("pre-reset result", result_o, sb_q.pop_front());
    #3;
    rst = 1'b1;
    #1;
    check("held reset ready", 64'(ready_o), 64'd0);
    check("held reset result", result_o, 64'd0);
    start_i = 1'b0;
    #2;
    rst = 1'b0;

    run_vec(vecs[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
